// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge read path.
package cart_pkg;

  localparam int CART_WORD_W         = 16;
  localparam int CART_BYTES_PER_WORD = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    RESTART = 2'd2
  } prefetch_state_t;

endpackage

// File: rtl/cart_word_fifo.sv
// DEPTH x 16-bit synchronous FIFO with flush and a registered head word.
// The head register is refreshed on the edge that moves the read pointer.
module cart_word_fifo
  import cart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [CART_WORD_W-1:0]       push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CART_WORD_W-1:0]       head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [CART_WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr, rd_ptr_n;
  logic [CNT_W-1:0]       count_n;
  logic                   do_push, do_pop, bypass;

  // A pop on an empty FIFO is only honoured when a word is pushed in the same cycle.
  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && ((count != '0) || do_push);
    rd_ptr_n = rd_ptr + PTR_W'(do_pop);
    count_n  = count + CNT_W'(do_push) - CNT_W'(do_pop);
    bypass   = do_push && (count == CNT_W'(do_pop));
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      // Head holds its last value while the FIFO is empty.
      if (count_n != '0) head <= bypass ? push_data : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/cart_read_prefetch.sv
// Cartridge ROM read prefetcher: refills a small word FIFO ahead of N64 read strobes.
// Optional CART_PREFETCH_STATS_EN adds a saturating underrun_count output.
module cart_read_prefetch
  import cart_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      start_addr,
  input  logic                   pop,
  output logic [CART_WORD_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   underrun,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [CART_WORD_W-1:0] mem_rdata
`ifdef CART_PREFETCH_STATS_EN
  ,
  output logic [15:0]            underrun_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);

  // Memory handshake: mem_req/mem_addr stay stable from raise until the mem_ack cycle;
  // one request outstanding at most, and mem_ack without mem_req is ignored.
  prefetch_state_t   state, state_n;
  logic [ADDR_W-1:0] fetch_addr, fetch_addr_n, pend_addr, pend_addr_n, start_even;
  logic [CNT_W-1:0]  count, count_post;
  logic              ack, push, flush, pop_eff, mem_req_n, underrun_n;

  always_comb begin
    start_even   = start_addr & ~ADDR_W'(1);
    ack          = mem_req && mem_ack;
    state_n      = state;
    fetch_addr_n = fetch_addr;
    pend_addr_n  = pend_addr;
    flush        = start;
    push         = 1'b0;
    mem_req_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          fetch_addr_n = start_even;
          state_n      = FETCH;
          mem_req_n    = 1'b1;
        end
      end
      FETCH: begin
        if (start) begin
          mem_req_n = 1'b1;
          // An ack in the same cycle as start belongs to the old burst.
          if (mem_req && !ack) begin
            pend_addr_n = start_even;
            state_n     = RESTART;
          end else begin
            fetch_addr_n = start_even;
          end
        end else begin
          push = ack;
          if (ack) fetch_addr_n = fetch_addr + ADDR_W'(CART_BYTES_PER_WORD);
        end
      end
      RESTART: begin
        mem_req_n = 1'b1;
        if (start) pend_addr_n = start_even;
        if (ack) begin
          fetch_addr_n = start ? start_even : pend_addr;
          state_n      = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
    pop_eff    = pop && !flush && ((count != '0) || push);
    count_post = count + CNT_W'(push) - CNT_W'(pop_eff);
    if (state == FETCH && !start)
      mem_req_n = (mem_req && !ack) || (count_post < CNT_W'(DEPTH));
    underrun_n = pop && !start && (count == '0) && !push;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fetch_addr <= '0;
      pend_addr  <= '0;
      mem_req    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      fetch_addr <= fetch_addr_n;
      pend_addr  <= pend_addr_n;
      mem_req    <= mem_req_n;
      underrun   <= underrun_n;
    end
  end

  assign mem_addr = fetch_addr;
  assign rd_valid = (count != '0);

  cart_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (mem_rdata),
    .pop       (pop_eff),
    .count     (count),
    .head      (rd_data)
  );

`ifdef CART_PREFETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) underrun_count <= '0;
    else if (underrun_n && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cart_read_prefetch.sv
// Bench for cart_read_prefetch: directed table, hand sequences and random traffic vs a stream model.
// Build with +define+CART_PREFETCH_STATS_EN to also check underrun_count.
module tb_cart_read_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, start, pop, mem_ack;
  logic [31:0] start_addr, mem_addr;
  logic [15:0] rd_data, mem_rdata;
  logic        rd_valid, underrun, mem_req;
`ifdef CART_PREFETCH_STATS_EN
  logic [15:0] underrun_count;
`endif

  cart_read_prefetch #(.ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .pop        (pop),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .underrun   (underrun),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
`ifdef CART_PREFETCH_STATS_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the popped stream is the ROM image read from the latest start address.
  int          m_count, m_und, req_age;
  logic [31:0] m_rd_addr, m_fetch;
  bit          m_active, m_stale;
  logic [31:0] act_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [15:0] word_at(input logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_und = 0; req_age = 0;
    m_active = 0; m_stale = 0;
    m_rd_addr = '0; m_fetch = '0;
  endtask

  task automatic do_reset();
    start = 0; pop = 0; mem_ack = 0; start_addr = '0; mem_rdata = '0;
    reset = 1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
`ifdef CART_PREFETCH_STATS_EN
    chk("rst_underrun_count", 32'(underrun_count), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  // One clock: drive inputs (memory answers after lat waiting cycles), advance model, check.
  task automatic cycle(input bit s, input logic [31:0] sa, input bit p, input int lat);
    bit ack, accepted, pop_eff, exp_und, hold;
    logic [31:0] hold_addr;
    ack = mem_req && (req_age >= lat);
    if (mem_req) req_age = ack ? 0 : req_age + 1;
    else         req_age = 0;
    start = s; start_addr = sa; pop = p; mem_ack = ack;
    mem_rdata = ack ? word_at(mem_addr) : 16'($urandom);
    accepted = ack && !s && !m_stale;
    pop_eff  = p && !s && (m_count > 0 || accepted);
    exp_und  = p && !s && m_count == 0 && !accepted;
    if (pop_eff && m_count > 0) chk("pop_data", 32'(rd_data), 32'(word_at(m_rd_addr)));
    hold = mem_req && !ack;
    hold_addr = mem_addr;
    if (s) begin
      m_stale = hold; m_count = 0; m_active = 1;
      m_rd_addr = sa & ~32'd1; m_fetch = sa & ~32'd1;
    end else begin
      if (ack) m_stale = 0;
      if (accepted) begin m_count++; m_fetch += 32'd2; end
      if (pop_eff) begin m_count--; m_rd_addr += 32'd2; end
    end
    if (exp_und) m_und++;
    @(posedge clk); #1;
    chk("rd_valid", 32'(rd_valid), 32'(m_count > 0));
    if (m_count > 0) chk("rd_data", 32'(rd_data), 32'(word_at(m_rd_addr)));
    chk("underrun", 32'(underrun), 32'(exp_und));
    chk("mem_req", 32'(mem_req), 32'(hold || (m_active && m_count < DEPTH)));
    if (hold) chk("mem_addr_hold", mem_addr, hold_addr);
    else if (mem_req) begin
      chk("mem_addr", mem_addr, m_fetch);
      act_q.push_back(mem_addr);
    end
`ifdef CART_PREFETCH_STATS_EN
    chk("underrun_count", 32'(underrun_count), 32'(m_und > 65535 ? 65535 : m_und));
`endif
  endtask

  typedef struct {
    bit          s;
    logic [31:0] a;
    bit          p;
    int          lat;
    bit          exp_req;
    bit          chk_addr;
    logic [31:0] exp_addr;
    bit          exp_valid;
    bit          exp_und;
  } vec_t;

  vec_t tbl[9];

  initial begin
    reset = 0; start = 0; pop = 0; mem_ack = 0; start_addr = '0; mem_rdata = '0;
    model_reset();
    #2;
    do_reset();

    // Address wrap with zero-wait memory, then flush-beats-pop and a real underrun.
    tbl[0] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h0,         1'b0, 0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 32'h0,         1'b0, 0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 32'h0,         1'b0, 0, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 32'h0,         1'b0, 0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_0301, 1'b1, 2, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 32'h0,         1'b1, 2, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 32'h0,         1'b0, 2, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 32'h0,         1'b0, 2, 1'b1, 1'b1, 32'h0000_0302, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].s, tbl[i].a, tbl[i].p, tbl[i].lat);
      chk($sformatf("tbl%0d_req", i), 32'(mem_req), 32'(tbl[i].exp_req));
      if (tbl[i].chk_addr) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_und", i), 32'(underrun), 32'(tbl[i].exp_und));
    end

    // Slow memory, no pops: exactly DEPTH requests, then idle with the first word at the head.
    act_q.delete();
    exp_q = '{32'h1000_0000, 32'h1000_0002, 32'h1000_0004, 32'h1000_0006};
    cycle(1, 32'h1000_0000, 0, 3);
    repeat (30) cycle(0, 0, 0, 3);
    chk("fill_req_count", 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("fill_req%0d", i), act_q[i], exp_q[i]);
    chk("fill_head", 32'(rd_data), 32'(word_at(32'h1000_0000)));
    chk("fill_idle_req", 32'(mem_req), 32'd0);

    // Zero-wait memory, fill then pop every cycle.
    cycle(1, 32'h0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0);
    repeat (16) cycle(0, 0, 1, 0);
    chk("stream_valid", 32'(rd_valid), 32'd1);

    // Pop straight after start on an empty FIFO.
    do_reset();
    cycle(1, 32'h0000_0400, 0, 2);
    cycle(0, 0, 1, 2);
    chk("early_pop_und", 32'(underrun), 32'd1);
    chk("early_pop_valid", 32'(rd_valid), 32'd0);
`ifdef CART_PREFETCH_STATS_EN
    chk("early_pop_count", 32'(underrun_count), 32'd1);
`endif
    cycle(0, 0, 0, 2);
    chk("early_pop_und_clr", 32'(underrun), 32'd0);

    // Restart while a request to the old burst is in flight.
    cycle(1, 32'h1000_0000, 0, 2);
    repeat (3) cycle(0, 0, 0, 2);
    chk("restart_old_addr", mem_addr, 32'h1000_0002);
    act_q.delete();
    cycle(1, 32'h2000_0000, 0, 2);
    repeat (8) cycle(0, 0, 0, 2);
    chk("restart_first_req", act_q.size() > 0 ? act_q[0] : 32'hDEAD_BEEF, 32'h2000_0000);
    chk("restart_head", 32'(rd_data), 32'(word_at(32'h2000_0000)));
    cycle(0, 0, 1, 2);

    // Reset mid-request with three words buffered, then a late ack.
    cycle(1, 32'h0000_0500, 0, 1);
    for (int i = 0; i < 40; i++) begin
      if (m_count == 3 && mem_req) break;
      cycle(0, 0, 0, 1);
    end
    chk("reset_setup", 32'(m_count == 3 && mem_req && rd_valid), 32'd1);
    #2;
    do_reset();
    mem_ack = 1; mem_rdata = 16'h1234;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("late_ack_valid", 32'(rd_valid), 32'd0);
    chk("late_ack_req", 32'(mem_req), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit          s;
      logic [31:0] sa;
      s  = (i == 0) || ($urandom_range(0, 19) == 0);
      sa = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      cycle(s, sa, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
